spi_master_ctrl: RTL

Host-side SPI master that drives one SPI execution-unit slave. Takes a command (operation code plus two 8-bit operands) over a start/busy/done handshake, serialises it MSB-first onto MOSI under its own generated SCLK and active-low chip select, then clocks the 21-bit response back off MISO and presents the 8-bit result and 4 flags. It sits directly upstream of the execution-unit slave, between the system bus and the SPI pins.

---
 rtl/spi_pkg.sv | 33 +++
 rtl/spi_clk_gen.sv | 36 +++
 rtl/spi_master_ctrl.sv | 136 +++++++++++++
 3 files changed

// File: rtl/spi_pkg.sv
// Shared types and frame constants for the SPI master controller and its clock generator.
package spi_pkg;

  localparam int OPER_W      = 4;
  localparam int ARG_W       = 8;
  localparam int RES_W       = 8;
  localparam int FLAG_W      = 4;
  localparam int SPI_TX_BITS = 24;
  localparam int SPI_RX_BITS = 21;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_TX,
    ST_GAP,
    ST_RX,
    ST_HOLD,
    ST_DONE
  } spi_master_state_t;

  // Command frame as it goes out on MOSI, MSB first.
  typedef struct packed {
    logic [OPER_W-1:0] oper;
    logic [3:0]        pad;
    logic [ARG_W-1:0]  arg_a;
    logic [ARG_W-1:0]  arg_b;
  } spi_cmd_t;

  function automatic int max_i(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/spi_clk_gen.sv
// SCLK divider: toggles sclk every CLK_DIV clocks while enabled and strobes rise/fall on the toggling cycle.
module spi_clk_gen #(
  parameter int CLK_DIV = 4
) (
  input  logic i_clk_p,
  input  logic i_rst,
  input  logic en,
  input  logic clr,
  output logic sclk,
  output logic rise,
  output logic fall
);

  localparam int CNT_W = $clog2(CLK_DIV);

  logic [CNT_W-1:0] cnt;
  logic             wrap;

  assign wrap = en && !clr && (cnt == CNT_W'(CLK_DIV - 1));
  assign rise = wrap && !sclk;
  assign fall = wrap && sclk;

  // Disabled or cleared parks the divider with SCLK low, so every burst starts on a full low half-period.
  always_ff @(posedge i_clk_p) begin
    if (i_rst || clr || !en) begin
      cnt  <= '0;
      sclk <= 1'b0;
    end else if (wrap) begin
      cnt  <= '0;
      sclk <= ~sclk;
    end else begin
      cnt  <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/spi_master_ctrl.sv
// SPI master: sends {oper,0,A,B}, idles GAP_BITS periods, reads {result,flags,pad} back.
// Optional abort input enabled by defining SPI_MASTER_ABORT_EN.
module spi_master_ctrl
  import spi_pkg::*;
#(
  parameter int CLK_DIV  = 4,
  parameter int TX_BITS  = SPI_TX_BITS,
  parameter int GAP_BITS = 2,
  parameter int RX_BITS  = SPI_RX_BITS
) (
  input  logic              i_clk_p,
  input  logic              i_rst,
  input  logic              i_start,
  input  logic [OPER_W-1:0] i_oper,
  input  logic [ARG_W-1:0]  i_argA,
  input  logic [ARG_W-1:0]  i_argB,
  output logic              o_busy,
  output logic              o_done,
  output logic [RES_W-1:0]  o_result,
  output logic [FLAG_W-1:0] o_flags,
  output logic              o_sclk,
  output logic              o_mosi,
  output logic              o_cs_n,
  input  logic              i_miso
`ifdef SPI_MASTER_ABORT_EN
  ,
  input  logic              i_abort
`endif
);

  localparam int CDIV_W  = $clog2(CLK_DIV);
  localparam int BCNT_W  = $clog2(max_i(TX_BITS, RX_BITS) + 1);
  localparam int FRAME_W = $bits(spi_cmd_t);

  spi_master_state_t   state_q, state_d;
  logic [CDIV_W-1:0]   hcnt;
  logic [BCNT_W-1:0]   bcnt;
  logic [TX_BITS-1:0]  tx_sr;
  logic [RX_BITS-1:0]  rx_sr;
  logic [TX_BITS-1:0]  frame;
  spi_cmd_t            cmd;
  logic                half_wrap, start_acc, abort_hit, clk_en;
  logic                sclk_rise, sclk_fall;
  logic                tx_end, gap_end, rx_end;

`ifdef SPI_MASTER_ABORT_EN
  assign abort_hit = i_abort && (state_q != ST_IDLE);
`else
  assign abort_hit = 1'b0;
`endif

  assign cmd       = '{oper: i_oper, pad: 4'b0, arg_a: i_argA, arg_b: i_argB};
  assign frame     = TX_BITS'(cmd) << (TX_BITS - FRAME_W);
  assign start_acc = (state_q == ST_IDLE) && i_start;
  assign half_wrap = (hcnt == CDIV_W'(CLK_DIV - 1));
  assign clk_en    = (state_q == ST_TX) || (state_q == ST_GAP) || (state_q == ST_RX);

  // bcnt counts rises, so a phase ends on the fall that completes its last period.
  assign tx_end  = sclk_fall && (bcnt == BCNT_W'(TX_BITS));
  assign gap_end = sclk_fall && (bcnt == BCNT_W'(GAP_BITS));
  assign rx_end  = sclk_fall && (bcnt == BCNT_W'(RX_BITS));

  spi_clk_gen #(.CLK_DIV(CLK_DIV)) u_clk_gen (
    .i_clk_p (i_clk_p),
    .i_rst   (i_rst),
    .en      (clk_en),
    .clr     (abort_hit),
    .sclk    (o_sclk),
    .rise    (sclk_rise),
    .fall    (sclk_fall)
  );

  always_ff @(posedge i_clk_p) begin
    if (i_rst) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (i_start)  state_d = ST_SETUP;
      ST_SETUP: if (half_wrap) state_d = ST_TX;
      ST_TX:    if (tx_end)   state_d = ST_GAP;
      ST_GAP:   if (gap_end)  state_d = ST_RX;
      ST_RX:    if (rx_end)   state_d = ST_HOLD;
      ST_HOLD:  if (half_wrap) state_d = ST_DONE;
      ST_DONE:                state_d = ST_IDLE;
      default:                state_d = ST_IDLE;
    endcase
    if (abort_hit) state_d = ST_IDLE;
  end

  always_ff @(posedge i_clk_p) begin
    if (i_rst) begin
      o_cs_n   <= 1'b1;
      o_mosi   <= 1'b0;
      o_busy   <= 1'b0;
      o_done   <= 1'b0;
      o_result <= '0;
      o_flags  <= '0;
      hcnt     <= '0;
      bcnt     <= '0;
      tx_sr    <= '0;
      rx_sr    <= '0;
    end else begin
      o_cs_n <= (state_d == ST_IDLE) || (state_d == ST_DONE);
      o_busy <= !abort_hit && (state_q != ST_IDLE) && (state_q != ST_DONE);
      o_done <= !abort_hit && (state_q == ST_DONE);
      if (!abort_hit && (state_q == ST_DONE)) begin
        o_result <= rx_sr[RX_BITS-1 -: RES_W];
        o_flags  <= rx_sr[RX_BITS-1-RES_W -: FLAG_W];
      end

      if (((state_q == ST_SETUP) || (state_q == ST_HOLD)) && !half_wrap) hcnt <= hcnt + CDIV_W'(1);
      else                                                                hcnt <= '0;

      if (state_d != state_q) bcnt <= '0;
      else if (sclk_rise)     bcnt <= bcnt + BCNT_W'(1);

      // MOSI only moves on a fall; the first bit is already on the wire before the first rise.
      if (start_acc) begin
        tx_sr  <= frame;
        o_mosi <= frame[TX_BITS-1];
      end else if ((state_q == ST_TX) && sclk_fall) begin
        tx_sr  <= tx_sr << 1;
        o_mosi <= tx_end ? 1'b0 : tx_sr[TX_BITS-2];
      end else if (state_d == ST_IDLE) begin
        o_mosi <= 1'b0;
      end

      if (start_acc)                            rx_sr <= '0;
      else if ((state_q == ST_RX) && sclk_fall) rx_sr <= {rx_sr[RX_BITS-2:0], i_miso};
    end
  end

endmodule
